// File: rtl/ha1588_axi_pkg.sv
// ha1588_axi_pkg
//   Shared definitions for the ha1588 AXI4-Lite register controller:
//   controller FSM state encoding, AXI response code and local-bus widths,
//   plus the byte-merge helper used by the optional read-modify-write path
//   (HA1588_AXI_WSTRB_RMW_EN).
package ha1588_axi_pkg;

  localparam int LB_ADDR_W = 8;
  localparam int LB_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // ST_RMW_RD / ST_RMW_WAIT are only ever entered when the RMW build
  // option is enabled.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_WAIT,
    ST_RMW_RD,
    ST_RMW_WAIT,
    ST_BRESP,
    ST_RRESP
  } axi_state_e;

  // Strobed bytes come from the new AXI data, the rest from the register's
  // current contents.
  function automatic logic [LB_DATA_W-1:0] merge_bytes(
    input logic [LB_DATA_W-1:0]   old_data,
    input logic [LB_DATA_W-1:0]   new_data,
    input logic [LB_DATA_W/8-1:0] strb
  );
    logic [LB_DATA_W-1:0] merged;
    merged = old_data;
    for (int b = 0; b < LB_DATA_W/8; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_data[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ha1588_axi_skid.sv
// ha1588_axi_skid
//   Generic one-entry capture buffer used for the AW, W and AR channels.
//   It accepts one beat while empty and holds it until the controller
//   clears it at the end of the owning transaction.
//
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       gates in_ready (held low until the first clock after reset)
//   in_valid     channel VALID
//   in_data      channel payload
//   clear        drop the held entry (transaction complete)
//   in_ready     channel READY (enabled and empty)
//   full         entry held
//   data         held payload
module ha1588_axi_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         clear,
  output logic         in_ready,
  output logic         full,
  output logic [W-1:0] data
);

  assign in_ready = enable && !full;

  // clear only occurs while full, so it can never collide with a fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      data <= in_data;
    end
  end

endmodule

// File: rtl/ha1588_axi_ctrl.sv
// ha1588_axi_ctrl
//   AXI4-Lite slave that sequences register accesses onto the ha1588 local
//   register bus, with at most one local access in flight. AW, W and AR are
//   captured in independent one-entry buffers; a write becomes eligible once
//   both AW and W are held, a read once AR is held. Simultaneous eligibility
//   alternates using a last-served bit. Responses are always OKAY.
//
//   Build option HA1588_AXI_WSTRB_RMW_EN: partial-strobe writes perform a
//   local read, merge the strobed bytes and write back; WSTRB=0 completes
//   without touching the local bus. Without it WSTRB is ignored.
//
//   Ports:
//     S_AXI_REG_ACLK / S_AXI_REG_ARESETN  clock, async active-low reset
//     S_AXI_REG_AW*, W*, B*, AR*, R*      AXI4-Lite slave channels
//     up_wr / up_rd                       one-cycle local write/read strobes
//     up_addr                             local byte address, [1:0] = 0
//     up_data_wr / up_data_rd             local write / read data
module ha1588_axi_ctrl
  import ha1588_axi_pkg::*;
#(
  parameter int C_S_AXI_REG_ADDR_WIDTH = 32,
  parameter int C_S_AXI_REG_DATA_WIDTH = 32,
  parameter int RD_LATENCY             = 1
) (
  input  logic                              S_AXI_REG_ACLK,
  input  logic                              S_AXI_REG_ARESETN,
  input  logic [C_S_AXI_REG_ADDR_WIDTH-1:0] S_AXI_REG_AWADDR,
  input  logic [2:0]                        S_AXI_REG_AWPROT,
  input  logic                              S_AXI_REG_AWVALID,
  output logic                              S_AXI_REG_AWREADY,
  input  logic [C_S_AXI_REG_DATA_WIDTH-1:0] S_AXI_REG_WDATA,
  input  logic [3:0]                        S_AXI_REG_WSTRB,
  input  logic                              S_AXI_REG_WVALID,
  output logic                              S_AXI_REG_WREADY,
  output logic [1:0]                        S_AXI_REG_BRESP,
  output logic                              S_AXI_REG_BVALID,
  input  logic                              S_AXI_REG_BREADY,
  input  logic [C_S_AXI_REG_ADDR_WIDTH-1:0] S_AXI_REG_ARADDR,
  input  logic [2:0]                        S_AXI_REG_ARPROT,
  input  logic                              S_AXI_REG_ARVALID,
  output logic                              S_AXI_REG_ARREADY,
  output logic [C_S_AXI_REG_DATA_WIDTH-1:0] S_AXI_REG_RDATA,
  output logic [1:0]                        S_AXI_REG_RRESP,
  output logic                              S_AXI_REG_RVALID,
  input  logic                              S_AXI_REG_RREADY,
  output logic                              up_wr,
  output logic                              up_rd,
  output logic [LB_ADDR_W-1:0]              up_addr,
  output logic [LB_DATA_W-1:0]              up_data_wr,
  input  logic [LB_DATA_W-1:0]              up_data_rd
);

  localparam logic [1:0] LAT = 2'(RD_LATENCY);

  axi_state_e state_reg, state_next;

  logic                 ready_en_reg;
  logic                 up_wr_reg, up_wr_next;
  logic                 up_rd_reg, up_rd_next;
  logic [LB_ADDR_W-1:0] up_addr_reg, up_addr_next;
  logic [LB_DATA_W-1:0] up_data_wr_reg, up_data_wr_next;
  logic [LB_DATA_W-1:0] rdata_reg, rdata_next;
  logic                 bvalid_reg, bvalid_next;
  logic                 rvalid_reg, rvalid_next;
  logic [1:0]           cnt_reg, cnt_next;
  logic                 last_rd_reg, last_rd_next;
  logic                 clear_wr, clear_rd;

  logic                 aw_full, w_full, ar_full;
  logic [LB_ADDR_W-1:0] aw_addr, ar_addr;
  logic [LB_DATA_W-1:0] w_data;
  logic [3:0]           w_strb;
  logic                 wr_elig, rd_elig;

  // Upper address bits and PROT carry no meaning on the local bus.
  logic unused_bits;
  assign unused_bits = ^{S_AXI_REG_AWPROT, S_AXI_REG_ARPROT,
                         S_AXI_REG_AWADDR[C_S_AXI_REG_ADDR_WIDTH-1:LB_ADDR_W],
                         S_AXI_REG_ARADDR[C_S_AXI_REG_ADDR_WIDTH-1:LB_ADDR_W]};

  // READY outputs stay low during reset and rise on the first clock after.
  always_ff @(posedge S_AXI_REG_ACLK or negedge S_AXI_REG_ARESETN) begin
    if (!S_AXI_REG_ARESETN) ready_en_reg <= 1'b0;
    else                    ready_en_reg <= 1'b1;
  end

  ha1588_axi_skid #(.W(LB_ADDR_W)) u_aw (
    .clk(S_AXI_REG_ACLK), .rst_n(S_AXI_REG_ARESETN), .enable(ready_en_reg),
    .in_valid(S_AXI_REG_AWVALID), .in_data(S_AXI_REG_AWADDR[LB_ADDR_W-1:0]),
    .clear(clear_wr), .in_ready(S_AXI_REG_AWREADY), .full(aw_full), .data(aw_addr)
  );

  ha1588_axi_skid #(.W(LB_DATA_W + 4)) u_w (
    .clk(S_AXI_REG_ACLK), .rst_n(S_AXI_REG_ARESETN), .enable(ready_en_reg),
    .in_valid(S_AXI_REG_WVALID), .in_data({S_AXI_REG_WSTRB, S_AXI_REG_WDATA}),
    .clear(clear_wr), .in_ready(S_AXI_REG_WREADY), .full(w_full), .data({w_strb, w_data})
  );

  ha1588_axi_skid #(.W(LB_ADDR_W)) u_ar (
    .clk(S_AXI_REG_ACLK), .rst_n(S_AXI_REG_ARESETN), .enable(ready_en_reg),
    .in_valid(S_AXI_REG_ARVALID), .in_data(S_AXI_REG_ARADDR[LB_ADDR_W-1:0]),
    .clear(clear_rd), .in_ready(S_AXI_REG_ARREADY), .full(ar_full), .data(ar_addr)
  );

`ifndef HA1588_AXI_WSTRB_RMW_EN
  logic unused_strb;
  assign unused_strb = ^w_strb;
`endif

  assign wr_elig = aw_full && w_full;
  assign rd_elig = ar_full;

  always_ff @(posedge S_AXI_REG_ACLK or negedge S_AXI_REG_ARESETN) begin
    if (!S_AXI_REG_ARESETN) begin
      state_reg      <= ST_IDLE;
      up_wr_reg      <= 1'b0;
      up_rd_reg      <= 1'b0;
      up_addr_reg    <= '0;
      up_data_wr_reg <= '0;
      rdata_reg      <= '0;
      bvalid_reg     <= 1'b0;
      rvalid_reg     <= 1'b0;
      cnt_reg        <= 2'd0;
      last_rd_reg    <= 1'b1;  // first conflict goes to the write
    end else begin
      state_reg      <= state_next;
      up_wr_reg      <= up_wr_next;
      up_rd_reg      <= up_rd_next;
      up_addr_reg    <= up_addr_next;
      up_data_wr_reg <= up_data_wr_next;
      rdata_reg      <= rdata_next;
      bvalid_reg     <= bvalid_next;
      rvalid_reg     <= rvalid_next;
      cnt_reg        <= cnt_next;
      last_rd_reg    <= last_rd_next;
    end
  end

  // Strobes are registered: the transition into WR / RD_WAIT / RMW_RD sets
  // the strobe for exactly that state's first cycle. up_addr/up_data_wr are
  // only loaded alongside a strobe so the local bus sees stable values.
  // cnt_reg counts read-wait cycles, the up_rd cycle being number 1.
  always_comb begin
    state_next      = state_reg;
    up_wr_next      = 1'b0;
    up_rd_next      = 1'b0;
    up_addr_next    = up_addr_reg;
    up_data_wr_next = up_data_wr_reg;
    rdata_next      = rdata_reg;
    bvalid_next     = bvalid_reg;
    rvalid_next     = rvalid_reg;
    cnt_next        = cnt_reg;
    last_rd_next    = last_rd_reg;
    clear_wr        = 1'b0;
    clear_rd        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (wr_elig && (!rd_elig || last_rd_reg)) begin
          last_rd_next = 1'b0;
`ifdef HA1588_AXI_WSTRB_RMW_EN
          if (w_strb == 4'h0) begin
            state_next  = ST_BRESP;
            bvalid_next = 1'b1;
          end else if (w_strb != 4'hF) begin
            state_next   = ST_RMW_RD;
            up_rd_next   = 1'b1;
            up_addr_next = {aw_addr[LB_ADDR_W-1:2], 2'b00};
            cnt_next     = 2'd1;
          end else begin
            state_next      = ST_WR;
            up_wr_next      = 1'b1;
            up_addr_next    = {aw_addr[LB_ADDR_W-1:2], 2'b00};
            up_data_wr_next = w_data;
          end
`else
          state_next      = ST_WR;
          up_wr_next      = 1'b1;
          up_addr_next    = {aw_addr[LB_ADDR_W-1:2], 2'b00};
          up_data_wr_next = w_data;
`endif
        end else if (rd_elig) begin
          last_rd_next = 1'b1;
          state_next   = ST_RD_WAIT;
          up_rd_next   = 1'b1;
          up_addr_next = {ar_addr[LB_ADDR_W-1:2], 2'b00};
          cnt_next     = 2'd1;
        end
      end

      ST_WR: begin
        state_next  = ST_BRESP;
        bvalid_next = 1'b1;
      end

      ST_BRESP: begin
        if (S_AXI_REG_BREADY) begin
          bvalid_next = 1'b0;
          clear_wr    = 1'b1;
          state_next  = ST_IDLE;
        end
      end

      ST_RD_WAIT: begin
        if (cnt_reg == LAT) begin
          rdata_next  = up_data_rd;
          rvalid_next = 1'b1;
          state_next  = ST_RRESP;
        end else begin
          cnt_next = cnt_reg + 2'd1;
        end
      end

      ST_RRESP: begin
        if (S_AXI_REG_RREADY) begin
          rvalid_next = 1'b0;
          clear_rd    = 1'b1;
          state_next  = ST_IDLE;
        end
      end

`ifdef HA1588_AXI_WSTRB_RMW_EN
      ST_RMW_RD, ST_RMW_WAIT: begin
        if (cnt_reg == LAT) begin
          state_next      = ST_WR;
          up_wr_next      = 1'b1;
          up_data_wr_next = merge_bytes(up_data_rd, w_data, w_strb);
        end else begin
          state_next = ST_RMW_WAIT;
          cnt_next   = cnt_reg + 2'd1;
        end
      end
`endif

      default: state_next = ST_IDLE;
    endcase
  end

  assign up_wr            = up_wr_reg;
  assign up_rd            = up_rd_reg;
  assign up_addr          = up_addr_reg;
  assign up_data_wr       = up_data_wr_reg;
  assign S_AXI_REG_BVALID = bvalid_reg;
  assign S_AXI_REG_BRESP  = RESP_OKAY;
  assign S_AXI_REG_RVALID = rvalid_reg;
  assign S_AXI_REG_RRESP  = RESP_OKAY;
  assign S_AXI_REG_RDATA  = rdata_reg;

endmodule
